// File: rtl/audio_sample_feeder.sv
// Sample-rate pacing FIFO: buffers PCM samples from a producer and presents one
// sample per sample-rate tick, priming before playback and emitting silence on underflow.
module audio_sample_feeder #(
  parameter int DEPTH       = 16,
  parameter int TICK_PERIOD = 2083,
  parameter int PREFILL     = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [15:0]                sample_in,
  input  logic                       sample_valid_in,
  output logic                       sample_ready_out,
  output logic [15:0]                sample_out,
  output logic                       sample_tick_out,
  output logic [$clog2(DEPTH):0]     fill_out,
  output logic                       underflow_out,
  input  logic                       underflow_clr_in
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(TICK_PERIOD);

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_PLAY  = 1'b1
  } state_t;

  state_t          r_state;
  logic [15:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [FW-1:0]   r_fill;
  logic [CW-1:0]   r_cnt;
  logic            r_tick;
  logic [15:0]     r_sample;
  logic            r_underflow;

  logic w_wrap;
  logic w_push;
  logic w_pop;
  logic w_under;

  assign w_wrap  = (r_cnt == CW'(TICK_PERIOD - 1));
  assign sample_ready_out = (r_fill < FW'(DEPTH)) && !rst_in;
  assign w_push  = sample_valid_in && sample_ready_out;
  assign w_pop   = (r_state == ST_PLAY) && w_wrap && (r_fill != '0);
  assign w_under = (r_state == ST_PLAY) && w_wrap && (r_fill == '0);

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= sample_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= ST_PRIME;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_cnt       <= '0;
      r_tick      <= 1'b0;
      r_sample    <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + CW'(1);
      r_tick <= w_wrap;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + FW'(1);
        2'b01:   r_fill <= r_fill - FW'(1);
        default: r_fill <= r_fill;
      endcase

      // Every tick refreshes the output: head of FIFO when playing, silence otherwise.
      if (w_wrap) begin
        r_sample <= w_pop ? r_mem[r_rd_ptr] : 16'd0;
      end

      case (r_state)
        ST_PRIME: begin
          if (r_fill >= FW'(PREFILL)) begin
            r_state <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (w_under) begin
            r_state <= ST_PRIME;
          end
        end
        default: r_state <= ST_PRIME;
      endcase

      if (w_under) begin
        r_underflow <= 1'b1;
      end else if (underflow_clr_in) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign sample_out      = r_sample;
  assign sample_tick_out = r_tick;
  assign fill_out        = r_fill;
  assign underflow_out   = r_underflow;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Randomized bench for audio_sample_feeder against a queue-based reference model
// that tracks ticks by counting edges since reset release.
module tb_audio_sample_feeder;

  localparam int DEPTH = 16;
  localparam int TP    = 10;
  localparam int PRE   = 8;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [15:0]   sample_in;
  logic          sample_valid_in;
  logic          sample_ready_out;
  logic [15:0]   sample_out;
  logic          sample_tick_out;
  logic [FW-1:0] fill_out;
  logic          underflow_out;
  logic          underflow_clr_in;

  always #5 clk_in = ~clk_in;

  audio_sample_feeder #(
    .DEPTH       (DEPTH),
    .TICK_PERIOD (TP),
    .PREFILL     (PRE)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .sample_ready_out (sample_ready_out),
    .sample_out       (sample_out),
    .sample_tick_out  (sample_tick_out),
    .fill_out         (fill_out),
    .underflow_out    (underflow_out),
    .underflow_clr_in (underflow_clr_in)
  );

  int n_chk = 0;
  int n_bad = 0;
  int n_ticks = 0;

  // Reference model state: values visible after the most recent edge.
  logic [15:0] m_q[$];
  bit          m_play   = 1'b0;
  logic [15:0] m_sample = 16'd0;
  bit          m_tick   = 1'b0;
  bit          m_uf     = 1'b0;
  int          m_edges  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [15:0] d, input bit clr);
    int f;
    bit te;
    bit push;
    bit uf_set;
    @(negedge clk_in);
    chk("sample_out", 32'(sample_out), 32'(m_sample));
    chk("tick", 32'(sample_tick_out), 32'(m_tick));
    chk("fill", 32'(fill_out), 32'(m_q.size()));
    chk("underflow", 32'(underflow_out), 32'(m_uf));
    if (m_tick) begin
      n_ticks++;
      $display("tick %0d: sample=%0d fill=%0d uf=%0b", n_ticks, m_sample, m_q.size(), m_uf);
    end
    rst_in = r;
    sample_valid_in = v;
    sample_in = d;
    underflow_clr_in = clr;
    #1;
    chk("ready", 32'(sample_ready_out), 32'((m_q.size() < DEPTH) && !r));
    @(posedge clk_in);
    if (r) begin
      m_q.delete();
      m_play = 1'b0;
      m_sample = 16'd0;
      m_tick = 1'b0;
      m_uf = 1'b0;
      m_edges = 0;
    end else begin
      f = m_q.size();
      m_edges++;
      te = (m_edges % TP) == 0;
      push = v && (f < DEPTH);
      uf_set = 1'b0;
      if (te) begin
        if (m_play && f > 0) begin
          m_sample = m_q.pop_front();
        end else begin
          m_sample = 16'd0;
          if (m_play) uf_set = 1'b1;
        end
      end
      if (!m_play && f >= PRE) m_play = 1'b1;
      else if (m_play && te && f == 0) m_play = 1'b0;
      if (uf_set) m_uf = 1'b1;
      else if (clr) m_uf = 1'b0;
      if (push) m_q.push_back(d);
      m_tick = te;
    end
  endtask

  int valid_pct[6] = '{100, 5, 15, 50, 30, 100};
  int rst_pml[6]   = '{0, 0, 0, 4, 0, 2};

  initial begin
    rst_in = 1'b1;
    sample_valid_in = 1'b0;
    sample_in = 16'd0;
    underflow_clr_in = 1'b0;
    @(posedge clk_in);

    // Idle after reset: ticks with silence, no underflow.
    step(1'b1, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 35; i++) step(1'b0, 1'b0, 16'd0, 1'b0);

    // Prime with 1..8, then drain to underflow while clear is held high.
    step(1'b1, 1'b0, 16'd0, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 16'(i), 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 16'd0, 1'b1);

    // Drain again without clear so the sticky flag is observed, then clear it.
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 16'(100 + i), 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 16'd0, 1'b0);
    step(1'b0, 1'b0, 16'd0, 1'b1);
    step(1'b0, 1'b0, 16'd0, 1'b0);

    // Backpressure: hold valid well past full.
    step(1'b1, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 16'(16'h8000 + i), 1'b0);

    // Reset mid-play, then idle to see tick phase restart.
    step(1'b1, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 16'd0, 1'b0);

    // Randomized phases with varied producer rates, clears and resets.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 400; i++) begin
        step(($urandom_range(0, 999) < rst_pml[p]),
             ($urandom_range(0, 99) < valid_pct[p]),
             16'($urandom),
             ($urandom_range(0, 99) < 10));
      end
    end

    step(1'b0, 1'b0, 16'd0, 1'b0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
